doodle_motion: RTL and testbench

Motion generator that drives the doodle game state machine. It converts the state machine's one-hot state, the player's left/right buttons and the scroll flag into the doodle's screen position (object_x, object_y), jump progress (up_count) and vertical speed (vert_speed), which feed back into the state machine.
Updates are paced by an internal movement tick derived from the system clock. The block sits between the button debouncers and the doodle state machine, alongside the VGA controller.

---
 rtl/doodle_motion.sv | 171 +++++++++++++++++
 tb/tb_doodle_motion.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doodle_motion.sv
// Motion generator for the doodle: turns the game state machine's one-hot state,
// the left/right buttons and the scroll flag into position, jump progress and speed.
module doodle_motion #(
  parameter int TICK_DIV  = 500000,
  parameter int MAX_SPEED = 4,
  parameter int SLOW_ZONE = 40,
  parameter int H_SPEED   = 3,
  parameter int H_LEFT    = 144,
  parameter int H_RIGHT   = 774,
  parameter int X_START   = 459,
  parameter int Y_START   = 450
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        q_I,
  input  logic        q_Up,
  input  logic        q_Down,
  input  logic        q_Done,
  input  logic [9:0]  JUMP_HEIGHT,
  input  logic        is_in_middle,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [15:0] object_x,
  output logic [15:0] object_y,
  output logic [9:0]  up_count,
  output logic [3:0]  vert_speed,
  output logic        move_tick
);

  localparam int              CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [3:0]      VS_MAX   = 4'(MAX_SPEED);
  localparam logic [4:0]      VS_MAX5  = 5'(MAX_SPEED);
  localparam logic [10:0]     SZ       = 11'(SLOW_ZONE);
  localparam logic [16:0]     HS17     = 17'(H_SPEED);
  localparam logic [16:0]     HL17     = 17'(H_LEFT);
  localparam logic [16:0]     HR17     = 17'(H_RIGHT);
  localparam logic [15:0]     HL16     = 16'(H_LEFT);
  localparam logic [15:0]     HR16     = 16'(H_RIGHT);
  localparam logic [15:0]     XS16     = 16'(X_START);
  localparam logic [15:0]     YS16     = 16'(Y_START);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   x_q, x_d;
  logic [15:0]   y_q, y_d;
  logic [9:0]    up_q, up_d;
  logic [3:0]    vs_q, vs_d;
  logic          tick_q, tick_d;
  logic [1:0]    prev_q, prev_d;

  logic          tick_s;
  logic          legal_s;
  logic          up_entry_s;
  logic          down_entry_s;
  logic [10:0]   jh_s;
  logic [10:0]   thr_s;
  logic [10:0]   up_sum_s;
  logic [16:0]   x_left_s;
  logic [16:0]   x_right_s;
  logic [15:0]   hx_s;
  logic [15:0]   y_up_s;
  logic [16:0]   y_dn_s;
  logic [4:0]    vs_inc_s;

  // Datapath helpers: horizontal wrap, vertical steps and the slow-zone threshold
  always_comb begin
    tick_s       = (cnt_q == CNT_LAST);
    legal_s      = $onehot({q_I, q_Up, q_Down, q_Done});
    up_entry_s   = q_Up & ~prev_q[0];
    down_entry_s = q_Down & ~prev_q[1];
    jh_s         = {1'b0, JUMP_HEIGHT};
    if (jh_s < SZ) begin
      thr_s = 11'd0;
    end else begin
      thr_s = jh_s - SZ;
    end
    up_sum_s  = {1'b0, up_q} + {7'd0, vs_q};
    x_left_s  = {1'b0, x_q} - HS17;
    x_right_s = {1'b0, x_q} + HS17;
    y_up_s    = y_q - {12'd0, vs_q};
    y_dn_s    = {1'b0, y_q} + {13'd0, vs_q};
    vs_inc_s  = {1'b0, vs_q} + 5'd1;
    // bit 16 of the left result flags an underflow past zero
    if (btn_left && !btn_right) begin
      if (x_left_s[16] || (x_left_s < HL17)) begin
        hx_s = HR16;
      end else begin
        hx_s = x_left_s[15:0];
      end
    end else if (btn_right && !btn_left) begin
      if (x_right_s > HR17) begin
        hx_s = HL16;
      end else begin
        hx_s = x_right_s[15:0];
      end
    end else begin
      hx_s = x_q;
    end
  end

  // Next-state selection: idle forcing, entry handling, then tick-paced motion
  always_comb begin
    cnt_d  = tick_s ? '0 : (cnt_q + CNT_ONE);
    tick_d = tick_s;
    prev_d = {q_Down, q_Up};
    x_d    = x_q;
    y_d    = y_q;
    up_d   = up_q;
    vs_d   = vs_q;
    if (!legal_s) begin
      x_d = x_q;
    end else if (q_I) begin
      x_d  = XS16;
      y_d  = YS16;
      up_d = 10'd0;
      vs_d = 4'd1;
    end else if (q_Done) begin
      x_d = x_q;
    end else if (up_entry_s) begin
      up_d = 10'd0;
      vs_d = VS_MAX;
    end else if (down_entry_s) begin
      vs_d = 4'd1;
    end else if (tick_s) begin
      x_d = hx_s;
      if (q_Up) begin
        up_d = up_sum_s[10] ? 10'd1023 : up_sum_s[9:0];
        if (!is_in_middle) begin
          y_d = y_up_s;
        end else begin
          y_d = y_q;
        end
        vs_d = (up_sum_s >= thr_s) ? 4'd1 : VS_MAX;
      end else begin
        y_d  = y_dn_s[16] ? 16'hFFFF : y_dn_s[15:0];
        vs_d = (vs_inc_s > VS_MAX5) ? VS_MAX : vs_inc_s[3:0];
      end
    end else begin
      x_d = x_q;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      prev_q <= 2'b00;
      x_q    <= XS16;
      y_q    <= YS16;
      up_q   <= 10'd0;
      vs_q   <= 4'd1;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      prev_q <= prev_d;
      x_q    <= x_d;
      y_q    <= y_d;
      up_q   <= up_d;
      vs_q   <= vs_d;
    end
  end

  assign object_x   = x_q;
  assign object_y   = y_q;
  assign up_count   = up_q;
  assign vert_speed = vs_q;
  assign move_tick  = tick_q;

endmodule

// File: tb/tb_doodle_motion.sv
// Self-checking bench for doodle_motion with a small arithmetic reference model
// kept in integers and advanced once per clock edge.
module tb_doodle_motion;
  localparam int TD = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        q_I, q_Up, q_Down, q_Done;
  logic [9:0]  JUMP_HEIGHT;
  logic        is_in_middle, btn_left, btn_right;
  logic [15:0] object_x, object_y;
  logic [9:0]  up_count;
  logic [3:0]  vert_speed;
  logic        move_tick;
  logic [46:0] obs_vec;

  int total = 0;
  int bad   = 0;
  int m_x, m_y, m_up, m_vs, m_mt, m_phase, m_pu, m_pd;
  int ticks_seen = 0;

  doodle_motion #(.TICK_DIV(TD)) dut (
    .Clk(Clk), .Reset(Reset), .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done),
    .JUMP_HEIGHT(JUMP_HEIGHT), .is_in_middle(is_in_middle), .btn_left(btn_left),
    .btn_right(btn_right), .object_x(object_x), .object_y(object_y), .up_count(up_count),
    .vert_speed(vert_speed), .move_tick(move_tick)
  );

  always #5 Clk = ~Clk;

  assign obs_vec = {object_x, object_y, up_count, vert_speed, move_tick};

  function automatic logic [46:0] model_vec();
    logic [15:0] x16, y16;
    logic [9:0]  u10;
    logic [3:0]  v4;
    x16 = m_x[15:0];
    y16 = m_y[15:0];
    u10 = m_up[9:0];
    v4  = m_vs[3:0];
    return {x16, y16, u10, v4, (m_mt != 0)};
  endfunction

  task automatic model_reset();
    m_x = 459; m_y = 450; m_up = 0; m_vs = 1; m_mt = 0;
    m_phase = 0; m_pu = 0; m_pd = 0;
  endtask

  task automatic set_state(input logic i, input logic u, input logic d, input logic dn);
    q_I = i; q_Up = u; q_Down = d; q_Done = dn;
  endtask

  // One clock edge; the model consumes the same inputs the DUT saw at that edge.
  task automatic step();
    int tick, n, s, thr, nx;
    @(posedge Clk);
    if (Reset) begin
      model_reset();
    end else begin
      tick = ((m_phase % TD) == TD - 1) ? 1 : 0;
      m_phase++;
      n = int'(q_I) + int'(q_Up) + int'(q_Down) + int'(q_Done);
      if (n == 1) begin
        if (q_I) begin
          m_x = 459; m_y = 450; m_up = 0; m_vs = 1;
        end else if (q_Done) begin
          m_x = m_x;
        end else if (q_Up && m_pu == 0) begin
          m_up = 0; m_vs = 4;
        end else if (q_Down && m_pd == 0) begin
          m_vs = 1;
        end else if (tick == 1) begin
          nx = m_x;
          if (btn_left && !btn_right) begin
            nx = m_x - 3;
            if (nx < 144) nx = 774;
          end else if (btn_right && !btn_left) begin
            nx = m_x + 3;
            if (nx > 774) nx = 144;
          end
          m_x = nx;
          if (q_Up) begin
            s   = m_up + m_vs;
            thr = (JUMP_HEIGHT < 40) ? 0 : int'(JUMP_HEIGHT) - 40;
            if (!is_in_middle) m_y = (m_y - m_vs) & 65535;
            m_up = (s > 1023) ? 1023 : s;
            m_vs = (s >= thr) ? 1 : 4;
          end else begin
            m_y  = (m_y + m_vs > 65535) ? 65535 : m_y + m_vs;
            m_vs = (m_vs + 1 > 4) ? 4 : m_vs + 1;
          end
          ticks_seen++;
        end
      end
      m_pu = int'(q_Up);
      m_pd = int'(q_Down);
      m_mt = tick;
    end
    #1;
  endtask

  task automatic run_ticks(input int n);
    int target;
    target = ticks_seen + n;
    for (int c = 0; c < n * TD + 8 && ticks_seen < target; c++) step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    set_state(1'b1, 1'b0, 1'b0, 1'b0);
    JUMP_HEIGHT = 10'd200; is_in_middle = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    step(); step();
    Reset = 1'b0;
    total++;
    if (obs_vec !== {16'd459, 16'd450, 10'd0, 4'd1, 1'b0}) begin
      bad++; $display("FAIL reset_values: got %h want %h", obs_vec, {16'd459, 16'd450, 10'd0, 4'd1, 1'b0});
    end
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (move_tick !== ((i % TD) == TD - 1)) begin
        bad++; $display("FAIL tick_period[%0d]: got %0b want %0b", i, move_tick, ((i % TD) == TD - 1));
      end
      total++;
      if (obs_vec !== model_vec()) begin
        bad++; $display("FAIL reset_idle[%0d]: got %h want %h", i, obs_vec, model_vec());
      end
    end
  endtask

  task automatic test_jump();
    set_state(1'b0, 1'b1, 1'b0, 1'b0);
    JUMP_HEIGHT = 10'd200; is_in_middle = 1'b0;
    step();
    total++;
    if ({up_count, vert_speed} !== {10'd0, 4'd4} || obs_vec !== model_vec()) begin
      bad++; $display("FAIL up_entry: got up=%0d vs=%0d want up=0 vs=4", up_count, vert_speed);
    end
    run_ticks(1);
    total++;
    if ({up_count, object_y} !== {10'd4, 16'd446} || obs_vec !== model_vec()) begin
      bad++; $display("FAIL jump_t1: got up=%0d y=%0d want up=4 y=446", up_count, object_y);
    end
    run_ticks(39);
    total++;
    if ({up_count, object_y, vert_speed} !== {10'd160, 16'd290, 4'd1} || obs_vec !== model_vec()) begin
      bad++; $display("FAIL jump_t40: got up=%0d y=%0d vs=%0d want 160 290 1", up_count, object_y, vert_speed);
    end
    run_ticks(40);
    total++;
    if ({up_count, object_y, object_x} !== {10'd200, 16'd250, 16'd459} || obs_vec !== model_vec()) begin
      bad++; $display("FAIL jump_t80: got up=%0d y=%0d x=%0d want 200 250 459", up_count, object_y, object_x);
    end
  endtask

  task automatic test_fall();
    set_state(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    total++;
    if ({vert_speed, object_y, up_count} !== {4'd1, 16'd250, 10'd200} || obs_vec !== model_vec()) begin
      bad++; $display("FAIL down_entry: got vs=%0d y=%0d up=%0d want 1 250 200", vert_speed, object_y, up_count);
    end
    run_ticks(5);
    total++;
    if ({object_y, vert_speed} !== {16'd264, 4'd4} || obs_vec !== model_vec()) begin
      bad++; $display("FAIL fall_5: got y=%0d vs=%0d want y=264 vs=4", object_y, vert_speed);
    end
  endtask

  task automatic test_middle();
    set_state(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    total++;
    if (obs_vec[46:1] !== {16'd459, 16'd450, 10'd0, 4'd1}) begin
      bad++; $display("FAIL idle_force: got %h want %h", obs_vec[46:1], {16'd459, 16'd450, 10'd0, 4'd1});
    end
    set_state(1'b0, 1'b1, 1'b0, 1'b0);
    is_in_middle = 1'b0;
    step();
    run_ticks(10);
    total++;
    if ({object_y, up_count} !== {16'd410, 10'd40} || obs_vec !== model_vec()) begin
      bad++; $display("FAIL mid_t10: got y=%0d up=%0d want 410 40", object_y, up_count);
    end
    is_in_middle = 1'b1;
    run_ticks(70);
    total++;
    if ({object_y, up_count, vert_speed} !== {16'd410, 10'd200, 4'd1} || obs_vec !== model_vec()) begin
      bad++; $display("FAIL mid_t80: got y=%0d up=%0d vs=%0d want 410 200 1", object_y, up_count, vert_speed);
    end
  endtask

  task automatic test_wrap();
    int exp_x [6] = '{771, 774, 144, 147, 144, 774};
    int n_t   [6] = '{104, 1, 1, 1, 1, 1};
    logic [15:0] ex;
    for (int k = 0; k < 6; k++) begin
      btn_right = (k < 4) ? 1'b1 : 1'b0;
      btn_left  = (k < 4) ? 1'b0 : 1'b1;
      run_ticks(n_t[k]);
      ex = exp_x[k][15:0];
      total++;
      if (object_x !== ex || obs_vec !== model_vec()) begin
        bad++; $display("FAIL wrap[%0d]: got x=%0d want x=%0d", k, object_x, ex);
      end
    end
    btn_left = 1'b1; btn_right = 1'b1;
    run_ticks(3);
    total++;
    if (object_x !== 16'd774 || obs_vec !== model_vec()) begin
      bad++; $display("FAIL both_hold: got x=%0d want x=774", object_x);
    end
  endtask

  task automatic test_done_and_reset();
    logic [45:0] snap;
    int lat;
    set_state(1'b0, 1'b0, 1'b0, 1'b1);
    snap = model_vec() >> 1;
    for (int c = 0; c < 20 * TD; c++) begin
      btn_left = 1'($urandom); btn_right = 1'($urandom); is_in_middle = 1'($urandom);
      step();
      if (c % TD == 0) begin
        total++;
        if (obs_vec[46:1] !== snap || obs_vec !== model_vec()) begin
          bad++; $display("FAIL done_freeze[%0d]: got %h want %h", c, obs_vec[46:1], snap);
        end
      end
    end
    set_state(1'b0, 1'b1, 1'b0, 1'b0);
    step(); run_ticks(3); step();
    #2 Reset = 1'b1;
    #1;
    total++;
    if (obs_vec !== {16'd459, 16'd450, 10'd0, 4'd1, 1'b0}) begin
      bad++; $display("FAIL async_reset: got %h want %h", obs_vec, {16'd459, 16'd450, 10'd0, 4'd1, 1'b0});
    end
    step(); step();
    Reset = 1'b0;
    set_state(1'b1, 1'b0, 1'b0, 1'b0);
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      step();
      if (move_tick === 1'b1) lat = c;
    end
    total++;
    if (lat != TD) begin
      bad++; $display("FAIL restart_latency: got %0d cycles want %0d", lat, TD);
    end
  endtask

  task automatic test_random();
    int hold, sel;
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        hold = $urandom_range(60, 1);
        sel  = $urandom_range(9, 0);
        case (sel)
          0:       set_state(1'b1, 1'b0, 1'b0, 1'b0);
          1, 2, 3: set_state(1'b0, 1'b1, 1'b0, 1'b0);
          4, 5, 6: set_state(1'b0, 1'b0, 1'b1, 1'b0);
          7:       set_state(1'b0, 1'b0, 1'b0, 1'b1);
          8:       set_state(1'b0, 1'b0, 1'b0, 1'b0);
          default: set_state(1'b0, 1'b1, 1'b1, 1'b0);
        endcase
        JUMP_HEIGHT = 10'($urandom_range(1023, 0));
      end
      hold--;
      if ($urandom_range(3, 0) == 0) begin
        btn_left = 1'($urandom); btn_right = 1'($urandom); is_in_middle = 1'($urandom);
      end
      step();
      total++;
      if (obs_vec !== model_vec()) begin
        bad++; $display("FAIL random[%0d]: got %h want %h", c, obs_vec, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_jump();
    test_fall();
    test_middle();
    test_wrap();
    test_done_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
